// File: rtl/vxm_stream_issuer.sv
// Initiator side of the VXM operand/result interface.
// Holds a NUM_STREAMS x STREAM_DEPTH stream register file. On a command it streams LEN
// operand pairs into the VXM, one pair per cycle, and writes each result back into a
// destination stream one cycle after the pair is issued.
module vxm_stream_issuer #(
  parameter int unsigned MIN_VEC_LENGTH      = 16,
  parameter int unsigned NUM_TILES_PER_SLICE = 20,
  parameter int unsigned NUM_STREAMS         = 4,
  parameter int unsigned STREAM_DEPTH        = 8,
  localparam int unsigned SW = $clog2(NUM_STREAMS),
  localparam int unsigned AW = $clog2(STREAM_DEPTH)
) (
  input  logic                                                clk,
  input  logic                                                rst,
  // Host write port
  input  logic                                                wr_en,
  input  logic [SW-1:0]                                       wr_stream,
  input  logic [AW-1:0]                                       wr_addr,
  input  logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]  wr_data,
  output logic                                                wr_drop,
  // Host read port
  input  logic                                                rd_en,
  input  logic [SW-1:0]                                       rd_stream,
  input  logic [AW-1:0]                                       rd_addr,
  output logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]  rd_data,
  output logic                                                rd_valid,
  // Command port
  input  logic                                                cmd_valid,
  output logic                                                cmd_ready,
  input  logic [1:0]                                          cmd_op,
  input  logic [SW-1:0]                                       cmd_src1,
  input  logic [SW-1:0]                                       cmd_src2,
  input  logic [SW-1:0]                                       cmd_dst,
  input  logic [AW-1:0]                                       cmd_base,
  input  logic [AW:0]                                         cmd_len,
  // VXM interface
  output logic                                                vxm_enable,
  output logic [1:0]                                          operation,
  output logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]  srf_data1,
  output logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]  srf_data2,
  input  logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]  vxm_result,
  // Status
  output logic                                                busy,
  output logic                                                done
);

  typedef logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0] vec_t;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e         state_q, state_d;
  logic [AW:0]    k_q, k_d;
  logic [1:0]     op_q;
  logic [SW-1:0]  src1_q, src2_q, dst_q;
  logic [AW-1:0]  base_q;
  logic [AW:0]    len_q;

  vec_t           mem_q [NUM_STREAMS][STREAM_DEPTH];

  logic           wb_valid_q;
  logic [AW-1:0]  wb_addr_q;
  logic           wr_drop_q;
  logic           rd_valid_q;
  vec_t           rd_data_q;

  logic           cmd_accept;
  logic           host_wr;
  logic [AW-1:0]  issue_addr;

  assign cmd_accept = (state_q == StIdle) && cmd_valid;
  assign host_wr    = (state_q == StIdle) && wr_en;
  // Natural AW-bit overflow gives the modulo-STREAM_DEPTH wrap.
  assign issue_addr = base_q + k_q[AW-1:0];

  // Next-state and element counter.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          k_d     = '0;
          state_d = (cmd_len == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        k_d = k_q + (AW+1)'(1);
        if (k_q == len_q - (AW+1)'(1)) state_d = StDrain;
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, counter and latched command fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      dst_q   <= '0;
      base_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (cmd_accept) begin
        op_q   <= cmd_op;
        src1_q <= cmd_src1;
        src2_q <= cmd_src2;
        dst_q  <= cmd_dst;
        base_q <= cmd_base;
        len_q  <= cmd_len;
      end
    end
  end

  // Writeback pipeline: the result for an issued pair arrives one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
    end else begin
      wb_valid_q <= (state_q == StIssue);
      wb_addr_q  <= issue_addr;
    end
  end

  // Stream file storage; host writes only land in idle, writebacks only while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      if (host_wr)    mem_q[wr_stream][wr_addr] <= wr_data;
      if (wb_valid_q) mem_q[dst_q][wb_addr_q]   <= vxm_result;
    end
  end

  // Registered host read and write-drop indication.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wr_drop_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= mem_q[rd_stream][rd_addr];
      wr_drop_q  <= wr_en && (state_q != StIdle);
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    vxm_enable = (state_q == StIssue);
    operation  = op_q;
    srf_data1  = mem_q[src1_q][issue_addr];
    srf_data2  = mem_q[src2_q][issue_addr];
    cmd_ready  = (state_q == StIdle);
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    rd_data    = rd_data_q;
    rd_valid   = rd_valid_q;
    wr_drop    = wr_drop_q;
  end

endmodule
